// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand driver: float field layout, status codes, FSM states.
package fpu_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 6;
    localparam int MANT_W   = 25;
    localparam int EXP_BIAS = 31;

    localparam logic [3:0] EXACT     = 4'b0001;
    localparam logic [3:0] OVERFLOW  = 4'b0010;
    localparam logic [3:0] UNDERFLOW = 4'b0100;
    localparam logic [3:0] INEXACT   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } drv_state_t;

    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fpu_driver.sv
// Feeds queued operand pairs to a fixed-latency FPU and captures each result
// into a valid/ready output register.
module fpu_driver
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 8
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op_a,
    input  logic [31:0] in_op_b,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_status,
    output logic        res_error
);
    drv_state_t  state;
    drv_state_t  next_state;
    logic [7:0]  cnt;
    logic        pop;
    logic        capture;
    logic        release_res;
    logic        full;
    logic        empty;
    logic [63:0] head;

    assign in_ready = !full;

    sync_fifo #(
        .WIDTH(64),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clock100KHz),
        .reset(reset),
        .push (in_valid),
        .pop  (pop),
        .wdata({in_op_a, in_op_b}),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd1) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    // Launch the next pair in the same edge to avoid an IDLE bubble
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = WAIT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_A_out   <= '0;
            op_B_out   <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_status <= '0;
            res_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) begin
                op_A_out <= head[63:32];
                op_B_out <= head[31:0];
                cnt      <= 8'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
            if (capture) begin
                res_data   <= fpu_data_in;
                res_status <= fpu_status_in;
                res_error  <= !is_onehot(fpu_status_in);
                res_valid  <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_driver.sv
// Directed and randomized bench for fpu_driver with a fixed-latency FPU model.
module tb_fpu_driver;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 8;
    localparam logic [31:0] OP_A = 32'h15000000;
    localparam logic [31:0] OP_B = 32'h15400000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        res_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_driver #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clock100KHz  (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .op_A_out     (op_A_out),
        .op_B_out     (op_B_out),
        .fpu_data_in  (fpu_data_in),
        .fpu_status_in(fpu_status_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_status   (res_status),
        .res_error    (res_error)
    );

    // Behavioural FPU: the true result is present only on the cycle it becomes valid
    function automatic logic [31:0] fpu_res(input logic [31:0] a, input logic [31:0] b);
        if (a == OP_A && b == OP_B) return 32'h15A00000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h00001357;
    endfunction

    function automatic logic [3:0] fpu_st(input logic [31:0] a);
        if (a[3:2] == 2'b11) return 4'b0011;
        return 4'b0001 << a[1:0];
    endfunction

    logic [63:0] last_ops = '0;
    int          age = 0;

    always begin
        @(posedge clk);
        #2;
        if ({op_A_out, op_B_out} !== last_ops) begin
            last_ops = {op_A_out, op_B_out};
            age = 0;
        end else if (age < 1000) begin
            age++;
        end
        if (age == LATENCY - 1) begin
            fpu_data_in   = fpu_res(op_A_out, op_B_out);
            fpu_status_in = fpu_st(op_A_out);
        end else begin
            fpu_data_in   = ~fpu_res(op_A_out, op_B_out);
            fpu_status_in = 4'b0000;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [63:0] ops);
        logic [3:0] st;
        st = fpu_st(ops[63:32]);
        chk({tag, "_data"}, res_data, fpu_res(ops[63:32], ops[31:0]));
        chk({tag, "_status"}, 32'(res_status), 32'(st));
        chk({tag, "_error"}, 32'(res_error), 32'($countones(st) != 1));
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!res_valid && n < max_cycles) begin
            step;
            n++;
        end
        chk("wait_res_valid", 32'(res_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [63:0] sb[$];
    logic [63:0] e;
    logic [31:0] a;
    logic [31:0] b;
    int          accepted;
    int          last_t;
    int          t;
    int          seen;

    initial begin
        fpu_data_in   = '0;
        fpu_status_in = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op_a   = '0;
        in_op_b   = '0;
        res_ready = 1'b0;

        repeat (2) step;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op_a", op_A_out, 32'd0);
        chk("rst_op_b", op_B_out, 32'd0);
        reset = 1'b0;
        step;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single pair with exact latency
        in_valid = 1'b1;
        in_op_a  = OP_A;
        in_op_b  = OP_B;
        step;
        in_valid = 1'b0;
        chk("op_a_before_pop", op_A_out, 32'd0);
        step;
        chk("single_op_a", op_A_out, OP_A);
        chk("single_op_b", op_B_out, OP_B);
        repeat (7) step;
        chk("single_not_early", 32'(res_valid), 32'd0);
        step;
        chk("single_res_valid", 32'(res_valid), 32'd1);
        chk("single_data", res_data, 32'h15A00000);
        chk("single_status", 32'(res_status), 32'h1);
        chk("single_error", 32'(res_error), 32'd0);
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        chk("single_released", 32'(res_valid), 32'd0);
        chk("idle_op_a_kept", op_A_out, OP_A);

        // Non-one-hot status
        a = 32'h1500000C;
        b = $urandom;
        in_valid = 1'b1;
        in_op_a  = a;
        in_op_b  = b;
        step;
        in_valid = 1'b0;
        wait_valid(40);
        chk("err_status", 32'(res_status), 32'h3);
        chk("err_flag", 32'(res_error), 32'd1);
        chk("err_data", res_data, fpu_res(a, b));
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;

        // Fill while the consumer stalls
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_op_a = $urandom;
            in_op_b = $urandom;
            if (in_ready) begin
                accepted++;
                sb.push_back({in_op_a, in_op_b});
            end
            step;
        end
        in_valid = 1'b0;
        chk("fill_accepted", 32'(accepted), 32'(DEPTH + 1));
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        e = sb[0];
        chk("fill_op_a_frozen", op_A_out, e[63:32]);
        chk("fill_op_b_frozen", op_B_out, e[31:0]);

        // Drain back-to-back, checking order and spacing
        res_ready = 1'b1;
        last_t = -1;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            if (res_valid) begin
                e = sb.pop_front();
                chk_result("b2b", e);
                if (last_t >= 0) chk("b2b_interval", 32'(t - last_t), 32'(LATENCY + 1));
                last_t = t;
            end
            step;
            t++;
        end
        chk("b2b_drained", 32'(sb.size()), 32'd0);
        res_ready = 1'b0;
        sb.delete();

        // Randomized traffic against the scoreboard
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op_a   = $urandom;
            in_op_b   = $urandom;
            res_ready = ($urandom_range(0, 3) == 0);
            if (in_valid && in_ready) sb.push_back({in_op_a, in_op_b});
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious", 32'(res_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk_result("rand", e);
                end
            end
            step;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        t = 0;
        while (sb.size() > 0 && t < 400) begin
            if (res_valid) begin
                e = sb.pop_front();
                chk_result("rand_drain", e);
            end
            step;
            t++;
        end
        chk("rand_drained", 32'(sb.size()), 32'd0);
        step;
        res_ready = 1'b0;

        // Reset in the middle of WAIT with pairs still queued
        in_valid = 1'b1;
        in_op_a = 32'h11111111; in_op_b = 32'h22222222;
        step;
        in_op_a = 32'h33333333; in_op_b = 32'h44444444;
        step;
        in_op_a = 32'h55555555; in_op_b = 32'h66666666;
        step;
        in_valid = 1'b0;
        repeat (3) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_op_a", op_A_out, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) seen++;
            step;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        chk("midrst_fifo_empty_op_a", op_A_out, 32'd0);
        chk("midrst_fifo_empty_op_b", op_B_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
